// File: rtl/sc_shift_controller_pkg.sv
// Shared state encoding and load geometry for the slow-control
// shift controller.
package sc_shift_controller_pkg;

   localparam int SC_BYTES        = 77;
   localparam int SC_BITS         = SC_BYTES * 8;
   localparam int CLK_DIV_DEF     = 4;
   localparam int RSTB_CYCLES_DEF = 16;
   localparam int TIMEOUT_DEF     = 4096;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RSTB,
      ST_PREP,
      ST_WAIT_END,
      ST_FETCH,
      ST_LOAD,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_DONE
   } state_e;

endpackage

// File: rtl/sc_shift_controller_if.sv
// Generator, FIFO read side and ASIC slow-control pins of the
// shift controller.
interface sc_shift_controller_if;

   logic       Out_Prep_Start;
   logic       In_Prep_End;
   logic       Out_Fifo_Rd_En;
   logic [7:0] In_Fifo_Dout;
   logic       In_Fifo_Empty;
   logic       Out_SR_Ck;
   logic       Out_SR_In;
   logic       Out_SR_Rstb;
   logic       Out_SR_Select;
   logic       In_SR_Out;

   modport master (
      output Out_Prep_Start,
      output Out_Fifo_Rd_En,
      output Out_SR_Ck,
      output Out_SR_In,
      output Out_SR_Rstb,
      output Out_SR_Select,
      input  In_Prep_End,
      input  In_Fifo_Dout,
      input  In_Fifo_Empty,
      input  In_SR_Out
   );

   modport slave (
      input  Out_Prep_Start,
      input  Out_Fifo_Rd_En,
      input  Out_SR_Ck,
      input  Out_SR_In,
      input  Out_SR_Rstb,
      input  Out_SR_Select,
      output In_Prep_End,
      output In_Fifo_Dout,
      output In_Fifo_Empty,
      output In_SR_Out
   );

endinterface

// File: rtl/sc_clk_div.sv
// Half-period counter for the ASIC shift clock; phase_end marks the
// last Clk cycle of the current half-period.
module sc_clk_div #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic phase_end
);

   localparam logic [7:0] LAST = 8'(DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d     = cnt_q;
      phase_end = en && (cnt_q == LAST);
      if (clr || phase_end)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sc_shift_controller.sv
// Slow-control load sequencer: generator trigger, FIFO drain, serial shift.
// SC_READBACK_CHECK_EN adds a second pass that verifies In_SR_Out.
module sc_shift_controller
   import sc_shift_controller_pkg::*;
#(
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned RSTB_CYCLES = RSTB_CYCLES_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic Clk,
   input  logic Rst_N,
   input  logic Start_In,
   output logic Out_Busy,
   output logic Out_Done,
   output logic Out_Error,
   sc_shift_controller_if.master sc
);

   localparam logic [12:0] RSTB_LAST = 13'(RSTB_CYCLES - 1);
   localparam logic [12:0] TMO_LAST  = 13'(TIMEOUT - 1);
   localparam logic [6:0]  BYTE_LAST = 7'(SC_BYTES - 1);

   state_e      state_q, state_d;
   logic        start_in_d_q;
   logic        start_pls_q, start_pls_d;
   logic [12:0] tmo_q, tmo_d;
   logic [2:0]  bit_q, bit_d;
   logic [6:0]  byte_q, byte_d;
   logic [7:0]  sbyte_q, sbyte_d;
   logic        err_q, err_d;
   logic        div_clr, div_en, phase_end;
`ifdef SC_READBACK_CHECK_EN
   logic        pass_q, pass_d;
`else
   logic        unused_sr_out;
   assign unused_sr_out = sc.In_SR_Out;
`endif

   sc_clk_div #(.DIV(CLK_DIV)) u_div (
      .clk       (Clk),
      .rst_n     (Rst_N),
      .clr       (div_clr),
      .en        (div_en),
      .phase_end (phase_end)
   );

   assign Out_Error = err_q;

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      sbyte_d     = sbyte_q;
      err_d       = err_q;
`ifdef SC_READBACK_CHECK_EN
      pass_d      = pass_q;
`endif
      // edges seen while a load runs are dropped here
      start_pls_d = Start_In && !start_in_d_q && (state_q == ST_IDLE);
      div_clr     = 1'b1;
      div_en      = 1'b0;
      sc.Out_Prep_Start = 1'b0;
      sc.Out_Fifo_Rd_En = 1'b0;
      sc.Out_SR_Ck      = 1'b0;
      sc.Out_SR_In      = 1'b0;
      sc.Out_SR_Rstb    = 1'b1;
      sc.Out_SR_Select  = 1'b1;
      Out_Busy          = 1'b1;
      Out_Done          = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            sc.Out_SR_Select = 1'b0;
            Out_Busy         = 1'b0;
            if (start_pls_q) begin
               state_d = ST_RSTB;
               tmo_d   = '0;
               err_d   = 1'b0;
`ifdef SC_READBACK_CHECK_EN
               pass_d  = 1'b0;
`endif
            end
         end
         ST_RSTB: begin
            sc.Out_SR_Rstb = 1'b0;
            tmo_d          = tmo_q + 13'd1;
            if (tmo_q == RSTB_LAST)
               state_d = ST_PREP;
         end
         ST_PREP: begin
            sc.Out_Prep_Start = 1'b1;
            tmo_d             = '0;
            byte_d            = '0;
            state_d           = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            if (sc.In_Prep_End) begin
               state_d = ST_FETCH;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d   = tmo_q + 13'd1;
            end
         end
         ST_FETCH: begin
            if (!sc.In_Fifo_Empty) begin
               sc.Out_Fifo_Rd_En = 1'b1;
               state_d           = ST_LOAD;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d   = tmo_q + 13'd1;
            end
         end
         ST_LOAD: begin
            sbyte_d = sc.In_Fifo_Dout;
            bit_d   = '0;
            state_d = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            div_clr      = 1'b0;
            div_en       = 1'b1;
            sc.Out_SR_In = sbyte_q[7];
            if (phase_end) begin
               state_d = ST_SHIFT_HI;
`ifdef SC_READBACK_CHECK_EN
               // pass-1 bit i leaves the ASIC as pass-2 bit i goes in
               if (pass_q && (sc.In_SR_Out != sbyte_q[7]))
                  err_d = 1'b1;
`endif
            end
         end
         ST_SHIFT_HI: begin
            div_clr      = 1'b0;
            div_en       = 1'b1;
            sc.Out_SR_Ck = 1'b1;
            sc.Out_SR_In = sbyte_q[7];
            if (phase_end) begin
               sbyte_d = {sbyte_q[6:0], 1'b0};
               if (bit_q != 3'd7) begin
                  bit_d   = bit_q + 3'd1;
                  state_d = ST_SHIFT_LO;
               end else if (byte_q != BYTE_LAST) begin
                  byte_d  = byte_q + 7'd1;
                  tmo_d   = '0;
                  state_d = ST_FETCH;
               end else begin
`ifdef SC_READBACK_CHECK_EN
                  if (!pass_q) begin
                     pass_d  = 1'b1;
                     state_d = ST_PREP;
                  end else begin
                     state_d = ST_DONE;
                  end
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
         ST_DONE: begin
            sc.Out_SR_Select = 1'b0;
            Out_Busy         = 1'b0;
            Out_Done         = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state_q      <= ST_IDLE;
         start_in_d_q <= 1'b0;
         start_pls_q  <= 1'b0;
         tmo_q        <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         sbyte_q      <= '0;
         err_q        <= 1'b0;
`ifdef SC_READBACK_CHECK_EN
         pass_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         start_in_d_q <= Start_In;
         start_pls_q  <= start_pls_d;
         tmo_q        <= tmo_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         sbyte_q      <= sbyte_d;
         err_q        <= err_d;
`ifdef SC_READBACK_CHECK_EN
         pass_q       <= pass_d;
`endif
      end
   end

endmodule

// File: tb/tb_sc_shift_controller.sv
// Directed bench for sc_shift_controller with generator, FIFO and
// 616-bit ASIC shift-register models.
module tb_sc_shift_controller;
   import sc_shift_controller_pkg::*;

`ifdef SC_READBACK_CHECK_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int TMO  = TIMEOUT_DEF;
   localparam int SPAN = SC_BYTES * 14 * CLK_DIV_DEF
                       + (SC_BYTES - 1) * (2 * CLK_DIV_DEF + 2);
   localparam int LOAD_BUDGET = NPASS * 6000 + 500;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_in = 1'b0;
   logic busy, done, err;

   int checks = 0;
   int errors = 0;

   sc_shift_controller_if bus();

   sc_shift_controller dut (
      .Clk       (clk),
      .Rst_N     (rst_n),
      .Start_In  (start_in),
      .Out_Busy  (busy),
      .Out_Done  (done),
      .Out_Error (err),
      .sc        (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // generator + FIFO model
   bit gen_en = 1'b1;
   bit gen_inc = 1'b0;
   int gen_dly = 0;
   int fill = 0;
   int pops = 0;
   int stall_after = -1;
   int stall_left = 0;
   logic [7:0] fifo_q[$];

   always @(posedge clk) begin
      int npush, npop;
      npush = 0;
      npop = 0;
      bus.In_Prep_End <= 1'b0;
      if (!rst_n) begin
         fifo_q.delete();
         fill <= 0;
         gen_dly <= 0;
         stall_left <= 0;
      end else begin
         if (bus.Out_Prep_Start && gen_en) gen_dly <= 5;
         else if (gen_dly != 0) gen_dly <= gen_dly - 1;
         if (gen_dly == 1) begin
            bus.In_Prep_End <= 1'b1;
            for (int i = 0; i < SC_BYTES; i++)
               fifo_q.push_back(gen_inc ? 8'(i) : 8'hA5);
            npush = SC_BYTES;
         end
         if (stall_left != 0) stall_left <= stall_left - 1;
         if (bus.Out_Fifo_Rd_En && fifo_q.size() != 0) begin
            bus.In_Fifo_Dout <= fifo_q.pop_front();
            npop = 1;
            pops <= pops + 1;
            if (pops + 1 == stall_after) stall_left <= 100;
         end
         fill <= fill + npush - npop;
      end
   end

   assign bus.In_Fifo_Empty = (fill == 0) || (stall_left != 0);

   // ASIC model
   logic [SC_BITS-1:0] asic = '0;
   int ck_edges = 0;
   bit flip = 1'b0;
   int flip_base = 0;
   logic got[$];

   always @(posedge bus.Out_SR_Ck) begin
      asic <= {asic[SC_BITS-2:0], bus.Out_SR_In};
      ck_edges <= ck_edges + 1;
      got.push_back(bus.Out_SR_In);
   end

   assign bus.In_SR_Out = asic[SC_BITS-1]
      ^ (flip && (ck_edges - flip_base == SC_BITS + 100));

   // event monitor
   logic ck_prev = 1'b0;
   int done_cnt = 0;
   int done_cyc = 0;
   int prep_cyc = 0;
   int rise_cyc[$];

   always @(negedge clk) begin
      if (bus.Out_SR_Ck && !ck_prev) rise_cyc.push_back(cyc);
      ck_prev = bus.Out_SR_Ck;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (bus.Out_Prep_Start) prep_cyc = cyc;
   end

   int e_base, r_base, d_base;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mark();
      e_base = got.size();
      r_base = rise_cyc.size();
      d_base = done_cnt;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic wait_done(string tag, int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_in_time"}, 32'(n < budget), 1);
      @(negedge clk);
   endtask

   task automatic check_load(string tag, bit inc, bit exp_err, int span);
      int n, mism, idx, sp;
      logic [7:0] bv;
      n = got.size() - e_base;
      chk({tag, "_edges"}, n, NPASS * SC_BITS);
      mism = 0;
      for (int i = 0; i < n; i++) begin
         idx = i % SC_BITS;
         bv = inc ? 8'(idx / 8) : 8'hA5;
         if (got[e_base + i] !== bv[7 - idx % 8]) mism++;
      end
      chk({tag, "_bits"}, mism, 0);
      sp = (rise_cyc.size() - r_base >= SC_BITS)
         ? rise_cyc[r_base + SC_BITS - 1] - rise_cyc[r_base] : -1;
      chk({tag, "_span"}, sp, span);
      chk({tag, "_done_once"}, done_cnt - d_base, 1);
      chk({tag, "_err_busy"}, {err, busy}, {exp_err, 1'b0});
   endtask

   initial begin
      int n;

      repeat (3) @(negedge clk);
      chk("reset", {busy, done, err, bus.Out_SR_Select, bus.Out_SR_Ck,
         bus.Out_SR_In, bus.Out_SR_Rstb, bus.Out_Prep_Start,
         bus.Out_Fifo_Rd_En}, 9'b000000100);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // plain A5 load, start-to-Rstb latency
      mark();
      start_in = 1'b1;
      @(negedge clk);
      chk("rstb_lat1", bus.Out_SR_Rstb, 1);
      @(negedge clk);
      chk("rstb_lat2", {bus.Out_SR_Rstb, bus.Out_SR_Select, busy}, 3'b011);
      start_in = 1'b0;
      wait_done("a5", LOAD_BUDGET);
      check_load("a5", 1'b0, 1'b0, SPAN);

      // start held high with a second edge while busy
      gen_inc = 1'b1;
      mark();
      start_in = 1'b1;
      repeat (200) @(negedge clk);
      start_in = 1'b0;
      repeat (3) @(negedge clk);
      start_in = 1'b1;
      wait_done("held", LOAD_BUDGET);
      check_load("held", 1'b1, 1'b0, SPAN);
      repeat (40) @(negedge clk);
      chk("held_no_relaunch", {done_cnt - d_base, 31'(busy)}, {32'd1, 31'd0});
      start_in = 1'b0;
      @(negedge clk);

      // generator never answers
      gen_en = 1'b0;
      mark();
      pulse_start();
      wait_done("tmo", TMO + 200);
      chk("tmo_err", err, 1);
      chk("tmo_latency", done_cyc - prep_cyc, TMO + 1);
      chk("tmo_edges", got.size() - e_base, 0);
      chk("tmo_done_once", done_cnt - d_base, 1);
      gen_en = 1'b1;

      // FIFO stalls for 100 cycles after byte 40
      gen_inc = 1'b0;
      stall_after = pops + 40;
      mark();
      pulse_start();
      @(negedge clk);
      chk("err_clear", err, 0);
      n = 0;
      while (stall_left != 10 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      chk("stall_reached", 32'(n < 8000), 1);
      chk("stall_hold", {bus.Out_SR_Ck, bus.Out_SR_Select, busy}, 3'b011);
      chk("stall_edges", got.size() - e_base, 320);
      wait_done("stall", LOAD_BUDGET);
      check_load("stall", 1'b0, 1'b0, SPAN + 35);
      stall_after = -1;

      // asynchronous reset in the middle of byte 30
      gen_inc = 1'b1;
      mark();
      pulse_start();
      n = 0;
      while (got.size() - e_base < 30 * 8 + 4 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached", 32'(n < 8000), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {busy, done, err, bus.Out_SR_Select, bus.Out_SR_Ck,
         bus.Out_SR_In, bus.Out_SR_Rstb, bus.Out_Prep_Start,
         bus.Out_Fifo_Rd_En}, 9'b000000100);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mark();
      pulse_start();
      wait_done("after_rst", LOAD_BUDGET);
      check_load("after_rst", 1'b1, 1'b0, SPAN);

`ifdef SC_READBACK_CHECK_EN
      // readback sees pass-2 bit 100 inverted
      mark();
      flip_base = ck_edges;
      flip = 1'b1;
      pulse_start();
      wait_done("rb_flip", LOAD_BUDGET);
      check_load("rb_flip", 1'b1, 1'b1, SPAN);
      flip = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
